secuenciador_imagenes: RTL

Image-sequencing controller for the LCD display path. It sits between the sync/address generation and the image ROM. It selects which of N images stored back-to-back in ROM is shown, adding that image's base offset to the per-pixel address. Image changes happen only at frame boundaries, either automatically after a programmable number of frames or manually on a push-button. A registered blank flag lets the colour stage force black during a changeover frame.

---
 rtl/secuenciador_imagenes_if.sv | 35 +++
 rtl/secuenciador_imagenes.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/secuenciador_imagenes_if.sv
// -----------------------------------------------------------------------------
// secuenciador_imagenes_if
//
// Pixel-path bus between the sync/address generator, the image sequencer and
// the colour stage.
//
//   VD       sync gen -> sequencer   vertical sync, active low
//   DEN      sync gen -> sequencer   data enable
//   Addr_in  sync gen -> sequencer   per-pixel address within one image
//   Addr_out sequencer -> ROM        image base + Addr_in, 1-cycle latency
//   DEN_out  sequencer -> colour     DEN aligned with Addr_out
//   Blank    sequencer -> colour     1 = force black for this frame
//
// Modports: master = sync generator / colour side, slave = sequencer.
// -----------------------------------------------------------------------------
interface secuenciador_imagenes_if #(
    parameter int ADDR_W = 17
);
    logic              VD;
    logic              DEN;
    logic [ADDR_W-1:0] Addr_in;
    logic [ADDR_W-1:0] Addr_out;
    logic              DEN_out;
    logic              Blank;

    modport master (
        output VD, DEN, Addr_in,
        input  Addr_out, DEN_out, Blank
    );

    modport slave (
        input  VD, DEN, Addr_in,
        output Addr_out, DEN_out, Blank
    );
endinterface

// File: rtl/secuenciador_imagenes.sv
// -----------------------------------------------------------------------------
// secuenciador_imagenes
//
// Image-sequencing controller for the LCD path. Selects one of N_IMG images
// stored back-to-back in ROM by adding a running base offset to the per-pixel
// address. Image changes happen only at frame start (falling VD), either after
// FRAMES_HOLD frames in auto mode or on a BTN_next press.
//
// Ports:
//   CLK       pixel clock
//   RST_n     synchronous reset, active low
//   BTN_next  push-button, asynchronous, active high: advance one image
//   BTN_mode  push-button, asynchronous, active high: toggle auto/manual
//   bus       slave side of secuenciador_imagenes_if (VD, DEN, Addr_in in;
//             Addr_out, DEN_out, Blank out)
//   Img_idx   index of the image currently displayed
//   Auto      1 = auto-advance mode
//
// Configuration macro: BLANK_SWITCH_EN
//   defined   -> SHOW/SWITCH state machine; each advance shows one black frame
//   undefined -> no SWITCH state, Blank tied to 0
// -----------------------------------------------------------------------------
module secuenciador_imagenes #(
    parameter int ADDR_W      = 17,
    parameter int IMG_WORDS   = 32768,
    parameter int N_IMG       = 4,
    parameter int FRAMES_HOLD = 120
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic                    BTN_next,
    input  logic                    BTN_mode,
    secuenciador_imagenes_if.slave  bus,
    output logic [3:0]              Img_idx,
    output logic                    Auto
);

    localparam int                CNT_W    = (FRAMES_HOLD > 1) ? $clog2(FRAMES_HOLD) : 1;
    localparam logic [ADDR_W-1:0] IMG_STEP = ADDR_W'(IMG_WORDS);
    localparam logic [3:0]        LAST_IDX = 4'(N_IMG - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAMES_HOLD - 1);

    // [0],[1] form the two-flop synchroniser; [2] is the history bit for
    // rising-edge detection.
    logic [2:0]        next_sync;
    logic [2:0]        mode_sync;
    logic              vd_q;
    logic              pend;
    logic [CNT_W-1:0]  frame_cnt;
    logic [ADDR_W-1:0] base;

    logic next_ev;
    logic mode_ev;
    logic fs;
    logic expiry;
    logic advance;

    assign next_ev = next_sync[1] & ~next_sync[2];
    assign mode_ev = mode_sync[1] & ~mode_sync[2];
    assign fs      = ~bus.VD & vd_q;
    assign expiry  = Auto && (frame_cnt == LAST_CNT);
    // pend is the registered flag, so a press landing in the FS cycle itself
    // is only latched here and waits for the following FS.
    assign advance = fs && (pend || expiry);

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            next_sync    <= '0;
            mode_sync    <= '0;
            vd_q         <= 1'b0;
            pend         <= 1'b0;
            frame_cnt    <= '0;
            base         <= '0;
            Img_idx      <= '0;
            Auto         <= 1'b1;
            bus.Addr_out <= '0;
            bus.DEN_out  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every right-hand
            // side sees the values from before this edge, whatever the order.
            next_sync    <= {next_sync[1:0], BTN_next};
            mode_sync    <= {mode_sync[1:0], BTN_mode};
            vd_q         <= bus.VD;
            bus.Addr_out <= bus.Addr_in + base;   // truncates to ADDR_W
            bus.DEN_out  <= bus.DEN;

            if (mode_ev) begin
                Auto <= ~Auto;
            end

            if (advance || mode_ev) begin
                frame_cnt <= '0;
            end else if (fs && Auto) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end

            if (next_ev) begin
                pend <= 1'b1;
            end else if (advance) begin
                pend <= 1'b0;
            end

            if (advance) begin
                if (Img_idx == LAST_IDX) begin
                    Img_idx <= '0;
                    base    <= '0;
                end else begin
                    Img_idx <= Img_idx + 4'd1;
                    base    <= base + IMG_STEP;
                end
            end
        end
    end

`ifdef BLANK_SWITCH_EN
    typedef enum logic {SHOW, SWITCH} state_t;

    state_t state;
    state_t state_nx;

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state <= SHOW;
        end else begin
            state <= state_nx;
        end
    end

    // An advance at the FS leaving SWITCH re-enters SWITCH, giving another
    // full black frame for the second image change.
    always_comb begin
        state_nx  = state;
        bus.Blank = (state == SWITCH);
        case (state)
            SHOW:    if (advance) state_nx = SWITCH;
            SWITCH:  if (fs)      state_nx = advance ? SWITCH : SHOW;
            default:              state_nx = SHOW;
        endcase
    end
`else
    assign bus.Blank = 1'b0;
`endif

endmodule
